// File: rtl/gshare_predictor.sv
// gshare_predictor
// -----------------------------------------------------------------------------
// Global-history branch direction predictor for the fetch stage. A pattern
// table of saturating counters is indexed by the PC combined with a
// speculative global history register. MODE picks the index function:
// 0 = gshare (XOR), 1 = gselect (concatenate), 2 = bimodal (PC only).
// After reset a sequential engine writes weakly-not-taken into every entry
// before predictions are allowed.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   init_busy          high while the table is being initialised
//   lookup_valid       fetch consumes a prediction this cycle (shifts history)
//   read_pc            PC of the fetched branch
//   prediction         1 = taken, combinational from read_pc and spec history
//   pred_hist          speculative history used for this lookup
//   update_valid       a branch resolved this cycle
//   update_pc          PC of the resolved branch
//   update_hist        pred_hist captured when that branch was looked up
//   update_taken       resolved direction
//   update_mispredict  resolved direction differed from the prediction
//
// PC_WIDTH must be greater than INDEX_WIDTH, HIST_WIDTH in 1..INDEX_WIDTH and
// CTR_WIDTH in 2..4.
// -----------------------------------------------------------------------------
module gshare_predictor #(
  parameter int PC_WIDTH    = 16,
  parameter int HIST_WIDTH  = 10,
  parameter int INDEX_WIDTH = 10,
  parameter int CTR_WIDTH   = 2,
  parameter int MODE        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  input  logic                  lookup_valid,
  input  logic [PC_WIDTH-1:0]   read_pc,
  output logic                  prediction,
  output logic [HIST_WIDTH-1:0] pred_hist,
  input  logic                  update_valid,
  input  logic [PC_WIDTH-1:0]   update_pc,
  input  logic [HIST_WIDTH-1:0] update_hist,
  input  logic                  update_taken,
  input  logic                  update_mispredict
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] init_ptr;
  logic [HIST_WIDTH-1:0]  spec_hist;
  logic [CTR_WIDTH-1:0]   pht [ENTRIES];

  logic [INDEX_WIDTH-1:0] lookup_idx;
  logic [INDEX_WIDTH-1:0] update_idx;
  logic [CTR_WIDTH-1:0]   upd_ctr;
  logic [CTR_WIDTH-1:0]   next_ctr;

  // Table index from a PC and a history value. The PC is halfword aligned, so
  // bit 0 never carries information and the index starts at bit 1. In gselect
  // mode the PC bits are shifted above the history; when the history fills the
  // whole index the shift pushes every PC bit out and the history stands alone.
  function automatic logic [INDEX_WIDTH-1:0] calc_idx(input logic [PC_WIDTH-1:0] pc,
                                                      input logic [HIST_WIDTH-1:0] h);
    logic [INDEX_WIDTH-1:0] pc_bits;
    logic [INDEX_WIDTH-1:0] h_ext;
    logic [INDEX_WIDTH-1:0] r;
    pc_bits = pc[INDEX_WIDTH:1];
    h_ext = '0;
    h_ext[HIST_WIDTH-1:0] = h;
    case (MODE)
      0:       r = pc_bits ^ h_ext;
      1:       r = (pc_bits << HIST_WIDTH) | h_ext;
      default: r = pc_bits;
    endcase
    return r;
  endfunction

  // Shift one outcome into the low end of a history value; the cast keeps the
  // newest HIST_WIDTH bits and also works for a one-bit history.
  function automatic logic [HIST_WIDTH-1:0] shift_in(input logic [HIST_WIDTH-1:0] h,
                                                     input logic b);
    return HIST_WIDTH'({h, b});
  endfunction

  assign lookup_idx = calc_idx(read_pc, spec_hist);
  assign update_idx = calc_idx(update_pc, update_hist);

  // Prediction is forced low until every counter holds a defined value, so
  // the uninitialised table never reaches the outputs.
  assign prediction = (state == ST_READY) ? pht[lookup_idx][CTR_WIDTH-1] : 1'b0;
  assign pred_hist  = spec_hist;
  assign init_busy  = (state == ST_INIT);

  // Saturating counter step for the resolved branch, read through the
  // second (update) read port.
  always_comb begin
    upd_ctr  = pht[update_idx];
    next_ctr = upd_ctr;
    if (update_taken) begin
      if (upd_ctr != CTR_MAX) next_ctr = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != '0) next_ctr = upd_ctr - 1'b1;
    end
  end

  // Control FSM and speculative history. INIT walks init_ptr over every entry
  // and leaves on the edge that writes the last one, so INIT lasts exactly
  // ENTRIES cycles. In READY a mispredict repair rebuilds the history from the
  // branch's own captured history plus its real outcome, and it wins over a
  // lookup shift in the same cycle because that lookup was on the wrong path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_ptr  <= '0;
      spec_hist <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == '1) state <= ST_READY;
        end
        ST_READY: begin
          if (update_valid && update_mispredict)
            spec_hist <= shift_in(update_hist, update_taken);
          else if (lookup_valid)
            spec_hist <= shift_in(spec_hist, prediction);
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Single write port shared by the init engine and branch updates. Updates
  // arriving during INIT are dropped. The lookup read is asynchronous, so a
  // same-cycle lookup of an entry being updated sees the old counter.
  always_ff @(posedge clk) begin
    if (state == ST_INIT)
      pht[init_ptr] <= CTR_WNT;
    else if (update_valid)
      pht[update_idx] <= next_ctr;
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor
// -----------------------------------------------------------------------------
// Self-checking bench for gshare_predictor. Three instances share the stimulus:
// dut0 gshare (defaults), dut1 gselect with a 4-bit history, dut2 bimodal.
// A reference model keeps each pattern table as an integer array and computes
// indices with plain arithmetic on the PC and history.
// -----------------------------------------------------------------------------
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid;
  logic [15:0] read_pc;
  logic        update_valid;
  logic [15:0] update_pc;
  logic [9:0]  update_hist;
  logic        update_taken;
  logic        update_mispredict;

  logic        busy0, busy1, busy2;
  logic        pred0, pred1, pred2;
  logic [9:0]  ph0;
  logic [3:0]  ph1;
  logic [9:0]  ph2;

  int checks = 0;
  int passes = 0;

  // Reference model state: counters per design, speculative history per design.
  int pht_m [3][1024];
  int sh_m  [3];
  int init_cnt;
  bit ready_m;

  always #5 clk = ~clk;

  gshare_predictor #(.MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .init_busy(busy0), .lookup_valid(lookup_valid),
    .read_pc(read_pc), .prediction(pred0), .pred_hist(ph0),
    .update_valid(update_valid), .update_pc(update_pc), .update_hist(update_hist),
    .update_taken(update_taken), .update_mispredict(update_mispredict));

  gshare_predictor #(.HIST_WIDTH(4), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .init_busy(busy1), .lookup_valid(lookup_valid),
    .read_pc(read_pc), .prediction(pred1), .pred_hist(ph1),
    .update_valid(update_valid), .update_pc(update_pc), .update_hist(update_hist[3:0]),
    .update_taken(update_taken), .update_mispredict(update_mispredict));

  gshare_predictor #(.MODE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .init_busy(busy2), .lookup_valid(lookup_valid),
    .read_pc(read_pc), .prediction(pred2), .pred_hist(ph2),
    .update_valid(update_valid), .update_pc(update_pc), .update_hist(update_hist),
    .update_taken(update_taken), .update_mispredict(update_mispredict));

  function automatic int hist_mod(int d);
    return (d == 1) ? 16 : 1024;
  endfunction

  // Index rules: gshare XORs the halfword PC with history, gselect places the
  // low 6 halfword-PC bits above the 4 history bits, bimodal uses the PC only.
  function automatic int midx(int d, int pc, int h);
    int p;
    p = (pc / 2) % 1024;
    case (d)
      0:       return p ^ h;
      1:       return ((pc / 2) % 64) * 16 + h;
      default: return p;
    endcase
  endfunction

  function automatic int mpred(int d, int pc);
    if (!ready_m) return 0;
    return (pht_m[d][midx(d, pc, sh_m[d])] >= 2) ? 1 : 0;
  endfunction

  // Model reset; tables are filled with weakly-not-taken straight away since
  // the model only reads them once init has completed.
  task automatic model_reset();
    init_cnt = 0;
    ready_m  = 0;
    for (int d = 0; d < 3; d++) begin
      sh_m[d] = 0;
      for (int i = 0; i < 1024; i++) pht_m[d][i] = 1;
    end
  endtask

  task automatic model_edge();
    int p, u, uh, hm, t;
    if (!ready_m) begin
      init_cnt++;
      if (init_cnt == 1024) ready_m = 1;
      return;
    end
    t = int'(update_taken);
    for (int d = 0; d < 3; d++) begin
      hm = hist_mod(d);
      uh = int'(update_hist) % hm;
      p  = mpred(d, int'(read_pc));
      if (update_valid) begin
        u = midx(d, int'(update_pc), uh);
        if (t == 1 && pht_m[d][u] < 3) pht_m[d][u]++;
        else if (t == 0 && pht_m[d][u] > 0) pht_m[d][u]--;
      end
      if (update_valid && update_mispredict) sh_m[d] = (uh * 2 + t) % hm;
      else if (lookup_valid) sh_m[d] = (sh_m[d] * 2 + p) % hm;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    lookup_valid      = 1'b0;
    read_pc           = 16'h0000;
    update_valid      = 1'b0;
    update_pc         = 16'h0000;
    update_hist       = 10'h000;
    update_taken      = 1'b0;
    update_mispredict = 1'b0;
  endtask

  task automatic random_inputs();
    lookup_valid      = 1'($urandom_range(0, 1));
    read_pc           = 16'($urandom_range(0, 31) * 2);
    update_valid      = 1'($urandom_range(0, 1));
    update_pc         = 16'($urandom_range(0, 31) * 2);
    update_hist       = 10'($urandom);
    update_taken      = 1'($urandom_range(0, 1));
    update_mispredict = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 7) == 0) read_pc = 16'($urandom);
  endtask

  task automatic start_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Count cycles until init completes, bounded so a stuck design still ends.
  task automatic wait_init(input bit rnd, output int n);
    n = 0;
    while (busy0 && n < 2000) begin
      if (rnd) random_inputs();
      step();
      n++;
    end
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    start_reset();
    checks++; if (busy0 !== 1'b1) $display("[TB] FAIL reset_busy: got %b expected 1", busy0); else passes++;
    checks++; if (pred0 !== 1'b0) $display("[TB] FAIL reset_pred: got %b expected 0", pred0); else passes++;
    checks++; if (ph0 !== 10'h000) $display("[TB] FAIL reset_hist: got %h expected 000", ph0); else passes++;
    release_reset();
    wait_init(1'b0, n);
    checks++; if (n != 1024) $display("[TB] FAIL init_cycles: got %0d expected 1024", n); else passes++;
    checks++; if (busy0 !== 1'b0) $display("[TB] FAIL init_done: got %b expected 0", busy0); else passes++;
    for (int i = 0; i < 4; i++) begin
      read_pc = 16'($urandom);
      #1;
      checks++; if (pred0 !== 1'b0 || pred1 !== 1'b0 || pred2 !== 1'b0)
        $display("[TB] FAIL first_pred pc=%h: got %b%b%b expected 000", read_pc, pred0, pred1, pred2);
      else passes++;
      checks++; if (ph0 !== 10'h000) $display("[TB] FAIL first_hist: got %h expected 000", ph0); else passes++;
    end
  endtask

  task automatic test_saturation();
    read_pc      = 16'h0010;
    update_valid = 1'b1;
    update_pc    = 16'h0010;
    update_hist  = 10'h000;
    update_taken = 1'b1;
    repeat (3) step();
    checks++; if (pred0 !== 1'b1) $display("[TB] FAIL sat_high: got %b expected 1", pred0); else passes++;
    update_taken = 1'b0;
    step();
    checks++; if (pred0 !== 1'b1) $display("[TB] FAIL sat_held: got %b expected 1", pred0); else passes++;
    repeat (3) step();
    checks++; if (pred0 !== 1'b0) $display("[TB] FAIL sat_low: got %b expected 0", pred0); else passes++;
    update_taken = 1'b1;
    repeat (2) step();
    update_valid = 1'b0;
    #1;
    checks++; if (pred0 !== 1'b1) $display("[TB] FAIL sat_floor: got %b expected 1", pred0); else passes++;
  endtask

  task automatic test_history_shift();
    logic [15:0] pcs   [3] = '{16'h0010, 16'h0040, 16'h0080};
    logic        preds [3] = '{1'b1, 1'b0, 1'b1};
    update_valid = 1'b1;
    update_pc    = 16'h0080;
    update_hist  = 10'h002;
    update_taken = 1'b1;
    step();
    update_valid = 1'b0;
    lookup_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      read_pc = pcs[i];
      #1;
      checks++; if (ph0 !== 10'(i)) $display("[TB] FAIL shift_hist%0d: got %h expected %h", i, ph0, 10'(i)); else passes++;
      checks++; if (pred0 !== preds[i]) $display("[TB] FAIL shift_pred%0d: got %b expected %b", i, pred0, preds[i]); else passes++;
      step();
    end
    lookup_valid = 1'b0;
    #1;
    checks++; if (ph0 !== 10'h005) $display("[TB] FAIL shift_final: got %h expected 005", ph0); else passes++;
  endtask

  task automatic test_repair();
    update_valid      = 1'b1;
    update_pc         = 16'h0000;
    update_hist       = 10'h3FF;
    update_taken      = 1'b1;
    update_mispredict = 1'b1;
    step();
    checks++; if (ph0 !== 10'h3FF) $display("[TB] FAIL repair_setup: got %h expected 3ff", ph0); else passes++;
    lookup_valid = 1'b1;
    read_pc      = 16'h0010;
    update_hist  = 10'h0A0;
    update_taken = 1'b0;
    step();
    idle_inputs();
    #1;
    checks++; if (ph0 !== 10'h140) $display("[TB] FAIL repair_override: got %h expected 140", ph0); else passes++;
  endtask

  task automatic test_collision();
    read_pc      = 16'h0200;
    update_valid = 1'b1;
    update_pc    = 16'h0200;
    update_hist  = 10'h140;
    update_taken = 1'b1;
    #1;
    checks++; if (pred0 !== 1'b0) $display("[TB] FAIL collide_same: got %b expected 0", pred0); else passes++;
    step();
    update_valid = 1'b0;
    #1;
    checks++; if (pred0 !== 1'b1) $display("[TB] FAIL collide_next: got %b expected 1", pred0); else passes++;
  endtask

  task automatic test_modes();
    int n;
    idle_inputs();
    start_reset();
    release_reset();
    wait_init(1'b0, n);
    checks++; if (n != 1024) $display("[TB] FAIL modes_init: got %0d expected 1024", n); else passes++;
    update_valid = 1'b1;
    update_pc    = 16'h0246;
    update_hist  = 10'h00A;
    update_taken = 1'b1;
    step();
    // Repair steers every history to ...1010 so gselect looks up with hist 0xA.
    update_pc         = 16'h0000;
    update_hist       = 10'h005;
    update_taken      = 1'b0;
    update_mispredict = 1'b1;
    step();
    idle_inputs();
    read_pc = 16'h0246;
    #1;
    checks++; if (ph1 !== 4'hA) $display("[TB] FAIL gsel_hist: got %h expected a", ph1); else passes++;
    checks++; if (pred1 !== 1'b1) $display("[TB] FAIL gsel_hit: got %b expected 1", pred1); else passes++;
    checks++; if (pred2 !== 1'b1) $display("[TB] FAIL bimodal_hit: got %b expected 1", pred2); else passes++;
    checks++; if (pred0 !== 1'b1) $display("[TB] FAIL gshare_hit: got %b expected 1", pred0); else passes++;
    read_pc = 16'h0248;
    #1;
    checks++; if (pred1 !== 1'b0 || pred2 !== 1'b0) $display("[TB] FAIL neighbour_248: got %b%b expected 00", pred1, pred2); else passes++;
    read_pc = 16'h0244;
    #1;
    checks++; if (pred1 !== 1'b0 || pred2 !== 1'b0) $display("[TB] FAIL neighbour_244: got %b%b expected 00", pred1, pred2); else passes++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      random_inputs();
      #1;
      checks++; if (pred0 !== 1'(mpred(0, int'(read_pc)))) $display("[TB] FAIL rnd_pred0 c%0d: got %b expected %0d", c, pred0, mpred(0, int'(read_pc))); else passes++;
      checks++; if (pred1 !== 1'(mpred(1, int'(read_pc)))) $display("[TB] FAIL rnd_pred1 c%0d: got %b expected %0d", c, pred1, mpred(1, int'(read_pc))); else passes++;
      checks++; if (pred2 !== 1'(mpred(2, int'(read_pc)))) $display("[TB] FAIL rnd_pred2 c%0d: got %b expected %0d", c, pred2, mpred(2, int'(read_pc))); else passes++;
      checks++; if (ph0 !== 10'(sh_m[0])) $display("[TB] FAIL rnd_hist0 c%0d: got %h expected %h", c, ph0, 10'(sh_m[0])); else passes++;
      checks++; if (ph1 !== 4'(sh_m[1])) $display("[TB] FAIL rnd_hist1 c%0d: got %h expected %h", c, ph1, 4'(sh_m[1])); else passes++;
      checks++; if (ph2 !== 10'(sh_m[2])) $display("[TB] FAIL rnd_hist2 c%0d: got %h expected %h", c, ph2, 10'(sh_m[2])); else passes++;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset_restart();
    int n;
    start_reset();
    release_reset();
    for (int i = 0; i < 500; i++) begin
      random_inputs();
      step();
    end
    start_reset();
    checks++; if (busy0 !== 1'b1) $display("[TB] FAIL restart_busy: got %b expected 1", busy0); else passes++;
    release_reset();
    wait_init(1'b1, n);
    checks++; if (n != 1024) $display("[TB] FAIL restart_cycles: got %0d expected 1024", n); else passes++;
    checks++; if (ph0 !== 10'h000 || ph1 !== 4'h0 || ph2 !== 10'h000)
      $display("[TB] FAIL init_drop_hist: got %h %h %h expected 0 0 0", ph0, ph1, ph2);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      read_pc = 16'($urandom_range(0, 31) * 2);
      #1;
      checks++; if (pred0 !== 1'b0 || pred1 !== 1'b0 || pred2 !== 1'b0)
        $display("[TB] FAIL init_drop_pred pc=%h: got %b%b%b expected 000", read_pc, pred0, pred1, pred2);
      else passes++;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_saturation();
    test_history_shift();
    test_repair();
    test_collision();
    test_modes();
    test_random();
    test_reset_restart();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
